prime_scan_ctrl: RTL and testbench
==================================

# prime_scan_ctrl

Sequential controller that scans every candidate from 2 up to a programmed limit. It decides primality by iterative trial division, one divisor per cycle. It keeps a running prime count and the last prime found, and reports completion through a start/busy/done handshake. It replaces the single-cycle lookup-table primality datapath with a time-multiplexed divider path, sized for limits up to 2^W−1.

## Interface
- `W`, 11: width of candidate, limit, count and divisor values
- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  begin scan; sampled only in IDLE
- `numMax`  in  W  inclusive upper limit; latched on accepted `start`
- `busy`  out  1  high while a scan is in progress
- `done`  out  1  one-cycle pulse at scan completion
- `numberChecked`  out  W  last candidate with a final verdict
- `prime`  out  1  verdict for `numberChecked`
- `numberOfPrimes`  out  W  primes found so far in this scan
- `lastPrime`  out  W  largest prime found so far in this scan; 0 if none
- `primeValid`  out  1  stream: a prime is offered (macro only)
- `primeReady`  in  1  stream: consumer accepts (macro only)
- `primeOut`  out  W  stream: prime value (macro only)

## Operation
- FSM states: IDLE, TEST, RESULT, EMIT (macro only), DONE.
- IDLE → TEST on `start`:
  - latch `numMax`
  - set n=2, d=2
  - clear `numberOfPrimes`, `lastPrime`, `numberChecked`, `prime`
- IDLE → DONE on `start` when the latched limit is below 2. The scan reports a count of 0.
- TEST, evaluated once per cycle in priority order:
  - (a) if d·d > n, the verdict is prime → RESULT
  - (b) else if n mod d == 0, the verdict is composite → RESULT
  - (c) else d = d+1 and stay in TEST
- d·d is computed at 2W bits, so it never overflows. n mod d is combinational.
- RESULT (one cycle):
  - `numberChecked`=n and `prime`=verdict
  - if the verdict is prime, `numberOfPrimes`+=1 and `lastPrime`=n
  - next state is EMIT if the macro is defined and the verdict is prime
  - otherwise, if n==numMax the next state is DONE; else n=n+1, d=2 → TEST
- EMIT:
  - hold `primeValid`=1 and `primeOut`=n until `primeReady`
  - on the handshake, leave by the same n==numMax rule as RESULT
- n never wraps, because the termination test happens before the increment.
- DONE (one cycle): `done`=1, `busy`=0, then → IDLE.
- Result outputs hold their values in IDLE until the next accepted `start`.
- `start` is ignored outside IDLE.
- `numMax` changes after `start` has no effect.
- `rst` in any state forces IDLE and clears every output to 0 on the next edge. A scan in progress is abandoned, with no `done`.

## Timing
- Every output resets to 0.
- `busy` is 1 in TEST, RESULT and EMIT.
- Accepting `start` at edge k gives `busy`=1 from k+1.
- With a limit below 2, `done`=1 during cycle k+1 and `busy` stays 0.
- Per-candidate latency is t+1 cycles, where t is the number of TEST cycles. Examples:
  - n=2: t=1
  - n=9: t=2 (d=2, then d=3 divides)
  - n=25: t=4
  - n=997: t=31
- The verdict for n is visible on `numberChecked`/`prime` from the edge that ends RESULT.
- `done` follows one cycle after the last candidate's RESULT, or after its EMIT handshake.
- Stream handshake:
  - `primeValid` rises the cycle after RESULT.
  - `primeOut` is stable while `primeValid`=1 and `primeReady`=0.
  - The transfer completes in the first cycle with both signals high, and `primeValid` drops on the next edge.

## Configuration
- `PRIME_SCAN_STREAM_EN` defined:
  - EMIT state and the stream ports are present
  - each prime is offered exactly once, in ascending order
  - backpressure stalls the scan
- `PRIME_SCAN_STREAM_EN` undefined:
  - no EMIT state
  - `primeValid`=0 and `primeOut`=0 are tied off
  - `primeReady` is ignored
  - scan timing is independent of the consumer

## Structure
- Package `prime_pkg` contains:
  - the default `W`
  - the FSM state enum `scan_state_t`
  - the constant `PRIME_MIN`=2
- Sub-module `prime_trial_div` holds the d register, the d·d compare and the n mod d compare. Its interface:
  - inputs: `clk`, `rst`, `load`, `n`
  - outputs: `verdictValid`, `isPrime`
- `prime_scan_ctrl` owns the FSM, the n register, and the count/result registers.

## Test plan
- `numMax`=10, `start` pulse → `done` once; `numberOfPrimes`=4, `lastPrime`=7, `numberChecked`=10, `prime`=0.
- `numMax`=1000 → `numberOfPrimes`=168, `lastPrime`=997. Each `numberChecked` update matches a reference primality model.
- `numMax`=0, 1 and 2:
  - 0 or 1 → `done` one cycle after `start`, count 0, `busy` never high
  - 2 → count 1, `lastPrime`=2
- `rst` asserted while n=50, then `start` with `numMax`=20 → no `done` before reset, all outputs 0 after reset, final count 8, `lastPrime`=19.
- Macro defined, `numMax`=30, `primeReady` toggled randomly → stream carries exactly 2, 3, 5, 7, 11, 13, 17, 19, 23, 29 with stable data under stall, then `done`.
- `start` re-pulsed while `busy` with a different `numMax` → ignored; the first scan's results are unchanged.

Source files
------------

// File: rtl/prime_pkg.sv
// Shared types and constants for the prime scan controller and its trial divider.
package prime_pkg;

    localparam int PRIME_W   = 11;
    localparam int PRIME_MIN = 2;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        TEST   = 3'd1,
        RESULT = 3'd2,
        EMIT   = 3'd3,
        DONE   = 3'd4
    } scan_state_t;

endpackage

// File: rtl/prime_trial_div.sv
// Iterative trial divider: holds divisor d, steps it by one per cycle until
// d*d exceeds n (prime) or d divides n (composite).
import prime_pkg::*;

module prime_trial_div #(
    parameter int W = PRIME_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] n,
    output logic         verdictValid,
    output logic         isPrime
);

    logic [W-1:0]   d_r;
    logic [2*W-1:0] sq_s;
    logic [W-1:0]   rem_s;

    // d never drops below PRIME_MIN, so the modulo never sees a zero divisor
    assign sq_s         = {{W{1'b0}}, d_r} * {{W{1'b0}}, d_r};
    assign rem_s        = n % d_r;
    assign isPrime      = (sq_s > {{W{1'b0}}, n});
    assign verdictValid = isPrime || (rem_s == {W{1'b0}});

    // Divisor register: restart on load, advance until a verdict is reached
    always_ff @(posedge clk) begin
        if (rst) begin
            d_r <= W'(PRIME_MIN);
        end else if (load) begin
            d_r <= W'(PRIME_MIN);
        end else if (!verdictValid) begin
            d_r <= d_r + W'(1);
        end
    end

endmodule

// File: rtl/prime_scan_ctrl.sv
// Scans candidates 2..numMax by trial division, counting primes.
// Optional prime output stream enabled by defining PRIME_SCAN_STREAM_EN.
import prime_pkg::*;

module prime_scan_ctrl #(
    parameter int W = PRIME_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] numMax,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] numberChecked,
    output logic         prime,
    output logic [W-1:0] numberOfPrimes,
    output logic [W-1:0] lastPrime,
    output logic         primeValid,
    input  logic         primeReady,
    output logic [W-1:0] primeOut
);

    scan_state_t  state_r, state_nx_s;
    logic [W-1:0] n_r;
    logic [W-1:0] max_r;
    logic         verdict_r;
    logic         load_s;
    logic         advance_s;
    logic         last_s;
    logic         verdict_valid_s;
    logic         is_prime_s;

    prime_trial_div #(.W(W)) u_div (
        .clk          (clk),
        .rst          (rst),
        .load         (load_s),
        .n            (n_r),
        .verdictValid (verdict_valid_s),
        .isPrime      (is_prime_s)
    );

    assign last_s    = (n_r == max_r);
    assign advance_s = load_s && (state_r != IDLE);

    // Next-state and divisor-load decode
    always_comb begin
        state_nx_s = state_r;
        load_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    load_s = 1'b1;
                    if (numMax < W'(PRIME_MIN)) begin
                        state_nx_s = DONE;
                    end else begin
                        state_nx_s = TEST;
                    end
                end else begin
                    state_nx_s = IDLE;
                end
            end
            TEST: begin
                if (verdict_valid_s) begin
                    state_nx_s = RESULT;
                end else begin
                    state_nx_s = TEST;
                end
            end
            RESULT: begin
`ifdef PRIME_SCAN_STREAM_EN
                if (verdict_r) begin
                    state_nx_s = EMIT;
                end else if (last_s) begin
                    state_nx_s = DONE;
                end else begin
                    state_nx_s = TEST;
                    load_s     = 1'b1;
                end
`else
                if (last_s) begin
                    state_nx_s = DONE;
                end else begin
                    state_nx_s = TEST;
                    load_s     = 1'b1;
                end
`endif
            end
`ifdef PRIME_SCAN_STREAM_EN
            EMIT: begin
                if (!(primeValid && primeReady)) begin
                    state_nx_s = EMIT;
                end else if (last_s) begin
                    state_nx_s = DONE;
                end else begin
                    state_nx_s = TEST;
                    load_s     = 1'b1;
                end
            end
`endif
            DONE:    state_nx_s = IDLE;
            default: state_nx_s = IDLE;
        endcase
    end

    // State, candidate and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r        <= IDLE;
            n_r            <= '0;
            max_r          <= '0;
            verdict_r      <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            numberChecked  <= '0;
            prime          <= 1'b0;
            numberOfPrimes <= '0;
            lastPrime      <= '0;
        end else begin
            state_r <= state_nx_s;
            busy    <= (state_nx_s == TEST) || (state_nx_s == RESULT) || (state_nx_s == EMIT);
            done    <= (state_nx_s == DONE);
            case (state_r)
                IDLE: begin
                    if (start) begin
                        max_r          <= numMax;
                        n_r            <= W'(PRIME_MIN);
                        numberChecked  <= '0;
                        prime          <= 1'b0;
                        numberOfPrimes <= '0;
                        lastPrime      <= '0;
                    end
                end
                TEST: begin
                    if (verdict_valid_s) begin
                        verdict_r <= is_prime_s;
                    end
                end
                RESULT: begin
                    numberChecked <= n_r;
                    prime         <= verdict_r;
                    if (verdict_r) begin
                        numberOfPrimes <= numberOfPrimes + W'(1);
                        lastPrime      <= n_r;
                    end
                    if (advance_s) begin
                        n_r <= n_r + W'(1);
                    end
                end
                EMIT: begin
                    if (advance_s) begin
                        n_r <= n_r + W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef PRIME_SCAN_STREAM_EN
    // Stream registers: offer the prime held in n while in EMIT
    always_ff @(posedge clk) begin
        if (rst) begin
            primeValid <= 1'b0;
            primeOut   <= '0;
        end else begin
            primeValid <= (state_nx_s == EMIT);
            primeOut   <= (state_nx_s == EMIT) ? n_r : '0;
        end
    end
`else
    logic unused_ready_s;
    assign unused_ready_s = primeReady;
    assign primeValid     = 1'b0;
    assign primeOut       = '0;
`endif

endmodule

// File: tb/tb_prime_scan_ctrl.sv
// Directed self-checking bench for prime_scan_ctrl; covers the stream path
// when PRIME_SCAN_STREAM_EN is defined.
module tb_prime_scan_ctrl;

    localparam int W = 11;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] numMax;
    logic         busy;
    logic         done;
    logic [W-1:0] numberChecked;
    logic         prime;
    logic [W-1:0] numberOfPrimes;
    logic [W-1:0] lastPrime;
    logic         primeValid;
    logic         primeReady;
    logic [W-1:0] primeOut;

    int pass_cnt = 0;
    int total_cnt = 0;
    int done_cnt = 0;
    int busy_cnt = 0;
    int cyc;
    bit mon_en = 1'b0;
    bit saw_stream = 1'b0;
    bit prev_stall = 1'b0;
    logic [W-1:0] prev_out = '0;
    logic [W-1:0] prev_checked = '0;
    int stream_q[$];

    prime_scan_ctrl #(.W(W)) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .numMax         (numMax),
        .busy           (busy),
        .done           (done),
        .numberChecked  (numberChecked),
        .prime          (prime),
        .numberOfPrimes (numberOfPrimes),
        .lastPrime      (lastPrime),
        .primeValid     (primeValid),
        .primeReady     (primeReady),
        .primeOut       (primeOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        if (obs !== exp) begin
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end else begin
            pass_cnt++;
        end
    endtask

    function automatic bit ref_prime(input int n);
        if (n < 2) return 1'b0;
        for (int i = 2; i < n; i++) begin
            if (n % i == 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    // Consumer readiness toggles randomly, away from the sampling edge
    initial begin
        primeReady = 1'b0;
        forever begin
            @(posedge clk);
            #2 primeReady = 1'($urandom_range(0, 1));
        end
    end

    // Monitor: verdict vs model, done/busy counting, stream capture
    always @(negedge clk) begin
        if (done) done_cnt++;
        if (busy) busy_cnt++;
        if (mon_en && numberChecked != prev_checked && numberChecked != '0) begin
            check_value("verdict", 32'(prime), 32'(ref_prime(int'(numberChecked))));
        end
        prev_checked = numberChecked;
        if (primeValid || primeOut != '0) saw_stream = 1'b1;
        if (mon_en && prev_stall) begin
            check_value("stall_valid", 32'(primeValid), 32'd1);
            check_value("stall_data", 32'(primeOut), 32'(prev_out));
        end
        if (primeValid && primeReady) stream_q.push_back(int'(primeOut));
        prev_stall = primeValid && !primeReady;
        prev_out   = primeOut;
    end

    task automatic start_scan(input int maxv);
        start  = 1'b1;
        numMax = W'(maxv);
        @(posedge clk);
        #1;
        start  = 1'b0;
        numMax = W'($urandom);
    endtask

    task automatic wait_done(input int budget, output int cycles);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (!done && cycles < budget);
        check_value("done_seen", 32'(done), 32'd1);
        @(negedge clk);
        check_value("done_pulse", 32'(done), 32'd0);
    endtask

    task automatic check_results(input int cnt, input int last, input int chk, input int pr);
        check_value("count", 32'(numberOfPrimes), 32'(cnt));
        check_value("last_prime", 32'(lastPrime), 32'(last));
        check_value("checked", 32'(numberChecked), 32'(chk));
        check_value("prime", 32'(prime), 32'(pr));
        check_value("busy_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        int d0;
        int wait_n;
        int exp_stream[10] = '{2, 3, 5, 7, 11, 13, 17, 19, 23, 29};
        rst    = 1'b1;
        start  = 1'b0;
        numMax = '0;
        repeat (2) @(negedge clk);
        check_value("rst_busy", 32'(busy), 32'd0);
        check_value("rst_done", 32'(done), 32'd0);
        check_value("rst_checked", 32'(numberChecked), 32'd0);
        check_value("rst_prime", 32'(prime), 32'd0);
        check_value("rst_count", 32'(numberOfPrimes), 32'd0);
        check_value("rst_last", 32'(lastPrime), 32'd0);
        check_value("rst_pvalid", 32'(primeValid), 32'd0);
        check_value("rst_pout", 32'(primeOut), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        mon_en = 1'b1;

        // numMax=10: 4 primes, done after 21 candidate cycles plus DONE
        d0 = done_cnt;
        start_scan(10);
        @(negedge clk);
        check_value("busy_rise", 32'(busy), 32'd1);
        wait_done(2000, cyc);
`ifndef PRIME_SCAN_STREAM_EN
        check_value("lat_10", 32'(cyc + 1), 32'd22);
`endif
        check_value("done_once_10", 32'(done_cnt - d0), 32'd1);
        check_results(4, 7, 10, 0);

        // Limits below 2 finish immediately without busy
        for (int m = 0; m < 2; m++) begin
            busy_cnt = 0;
            start_scan(m);
            wait_done(10, cyc);
            check_value("lat_small", 32'(cyc), 32'd1);
            check_value("busy_never", 32'(busy_cnt), 32'd0);
            check_results(0, 0, 0, 0);
        end

        // numMax=2: single prime
        start_scan(2);
        wait_done(100, cyc);
`ifndef PRIME_SCAN_STREAM_EN
        check_value("lat_2", 32'(cyc), 32'd3);
`endif
        check_results(1, 2, 2, 1);

        // numMax=1000 with every verdict checked by the monitor
        start_scan(1000);
        wait_done(40000, cyc);
        check_results(168, 997, 1000, 0);

        // Reset while n=50 abandons the scan
        start_scan(1000);
        wait_n = 0;
        while (numberChecked != W'(49) && wait_n < 5000) begin
            @(negedge clk);
            wait_n++;
        end
        check_value("reach_49", 32'(numberChecked), 32'd49);
        d0  = done_cnt;
        rst = 1'b1;
        @(negedge clk);
        check_value("mid_rst_done", 32'(done_cnt - d0), 32'd0);
        check_results(0, 0, 0, 0);
        check_value("mid_rst_pvalid", 32'(primeValid), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        start_scan(20);
        wait_done(2000, cyc);
        check_results(8, 19, 20, 0);

        // start re-pulsed while busy is ignored
        d0 = done_cnt;
        start_scan(10);
        repeat (3) @(negedge clk);
        start_scan(100);
        wait_done(2000, cyc);
        check_value("done_once_repulse", 32'(done_cnt - d0), 32'd1);
        check_results(4, 7, 10, 0);

`ifdef PRIME_SCAN_STREAM_EN
        stream_q.delete();
        start_scan(30);
        wait_done(5000, cyc);
        check_results(10, 29, 30, 0);
        check_value("stream_len", 32'(stream_q.size()), 32'd10);
        for (int i = 0; i < 10; i++) begin
            if (i < stream_q.size()) begin
                check_value("stream_val", 32'(stream_q[i]), 32'(exp_stream[i]));
            end
        end
`else
        check_value("stream_off", 32'(saw_stream), 32'd0);
        check_value("stream_q_empty", 32'(stream_q.size()), 32'd0);
        check_value("exp_first", 32'(exp_stream[0]), 32'(lastPrime) - 32'd5);
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
